// File: rtl/sum_display_if.sv
// Operand/result bundle for sum_display: the load handshake, the BCD result and the 7-segment drive.
// master = whoever supplies sums and watches the display; slave = sum_display itself.
interface sum_display_if;
    logic [5:0] sum_in;
    logic       load;
    logic       busy;
    logic       done;
    logic [2:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic [6:0] seg;
    logic [1:0] an;

    modport master (
        output sum_in, load,
        input  busy, done, bcd_tens, bcd_ones, seg, an
    );

    modport slave (
        input  sum_in, load,
        output busy, done, bcd_tens, bcd_ones, seg, an
    );
endinterface

// File: rtl/sum_display.sv
// Converts a 6-bit sum to two BCD digits by double dabble (6 clocks, load ignored while busy) and
// time-multiplexes them onto a two-digit active-low 7-segment display. Define SUM_DISPLAY_LZB_EN to blank a leading zero tens digit.
module sum_display #(
    parameter int REFRESH_BITS = 16
) (
    input  logic          clk,
    input  logic          rst,
    sum_display_if.slave  bus
);

    typedef enum logic {IDLE, CONV} state_t;

    state_t state_q, state_d;

    logic [5:0] bin_q, bin_d;
    logic [2:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic [2:0] iter_q, iter_d;

    logic [2:0] bcd_tens_q, bcd_tens_d;
    logic [3:0] bcd_ones_q, bcd_ones_d;
    logic       done_q, done_d;

    logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
    logic [6:0]              seg_q, seg_d;
    logic [1:0]              an_q, an_d;

    logic [2:0]  tens_adj;
    logic [3:0]  ones_adj;
    logic [12:0] shifted;

    logic       digit_sel;
    logic [3:0] digit;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // One double-dabble iteration: correct each nibble, then shift {tens,ones,bin} left.
    // The tens nibble can never reach 5 before the last shift for a 6-bit input, so 3 bits suffice.
    always_comb begin
        ones_adj = (ones_q >= 4'd5) ? ones_q + 4'd3 : ones_q;
        tens_adj = (tens_q >= 3'd5) ? tens_q + 3'd3 : tens_q;
        shifted  = {tens_adj, ones_adj, bin_q} << 1;
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        iter_d     = iter_q;
        bcd_tens_d = bcd_tens_q;
        bcd_ones_d = bcd_ones_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    bin_d   = bus.sum_in;
                    tens_d  = 3'd0;
                    ones_d  = 4'd0;
                    iter_d  = 3'd0;
                    state_d = CONV;
                end
            end
            CONV: begin
                tens_d = shifted[12:10];
                ones_d = shifted[9:6];
                bin_d  = shifted[5:0];
                iter_d = iter_q + 3'd1;
                if (iter_q == 3'd5) begin
                    bcd_tens_d = shifted[12:10];
                    bcd_ones_d = shifted[9:6];
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            tens_q     <= '0;
            ones_q     <= '0;
            iter_q     <= '0;
            bcd_tens_q <= '0;
            bcd_ones_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            iter_q     <= iter_d;
            bcd_tens_q <= bcd_tens_d;
            bcd_ones_q <= bcd_ones_d;
            done_q     <= done_d;
        end
    end

    // Display mux: counter MSB low shows ones, high shows tens; outputs registered.
    always_comb begin
        refresh_d = refresh_q + 1'b1;
        digit_sel = refresh_q[REFRESH_BITS-1];
        digit     = digit_sel ? {1'b0, bcd_tens_q} : bcd_ones_q;
        seg_d     = seg_decode(digit);
        an_d      = digit_sel ? 2'b01 : 2'b10;
`ifdef SUM_DISPLAY_LZB_EN
        if (digit_sel && (bcd_tens_q == 3'd0)) begin
            an_d  = 2'b11;
            seg_d = 7'b1111111;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_q <= '0;
            seg_q     <= 7'b1000000;
            an_q      <= 2'b10;
        end else begin
            refresh_q <= refresh_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign bus.busy     = (state_q == CONV);
    assign bus.done     = done_q;
    assign bus.bcd_tens = bcd_tens_q;
    assign bus.bcd_ones = bcd_ones_q;
    assign bus.seg      = seg_q;
    assign bus.an       = an_q;

endmodule

// File: tb/tb_sum_display.sv
// Directed bench for sum_display: stimulus pushes expected BCD results, a negedge monitor pops them on done.
module tb_sum_display;

    logic clk = 1'b0;
    logic rst;

    sum_display_if bus ();

    sum_display #(.REFRESH_BITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;
    int prev_done_cyc = 0;

    logic [6:0] exp_q[$];
    logic [6:0] mon_e;
    logic [2:0] prev_t = 3'd0;
    logic [3:0] prev_o = 4'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] dec(input int d);
        logic [6:0] s;
        case (d)
            0: s = 7'b1000000;
            1: s = 7'b1111001;
            2: s = 7'b0100100;
            3: s = 7'b0110000;
            4: s = 7'b0011001;
            5: s = 7'b0010010;
            6: s = 7'b0000010;
            7: s = 7'b1111000;
            8: s = 7'b0000000;
            9: s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.done === 1'b1) begin
            done_cnt++;
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("bcd_tens", int'(bus.bcd_tens), int'(mon_e[6:4]));
                check("bcd_ones", int'(bus.bcd_ones), int'(mon_e[3:0]));
                check("busy_at_done", int'(bus.busy), 0);
            end
        end
    end

    task automatic run_conv(input int v, input int et, input int eo);
        @(negedge clk);
        bus.sum_in = 6'(v);
        bus.load   = 1'b1;
        exp_q.push_back({3'(et), 4'(eo)});
        @(negedge clk);
        bus.load = 1'b0;
        check("busy_after_k", int'(bus.busy), 1);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check("busy_conv", int'(bus.busy), 1);
            check("done_early", int'(bus.done), 0);
            check("hold_tens", int'(bus.bcd_tens), int'(prev_t));
        end
        @(negedge clk);
        check("busy_end", int'(bus.busy), 0);
        check("done_k6", int'(bus.done), 1);
        prev_t = 3'(et);
        prev_o = 4'(eo);
    endtask

    task automatic check_display(input int t, input int o);
        bit seen_ones = 0;
        bit seen_tens = 0;
        logic [1:0] tens_an = 2'b01;
        logic [6:0] tens_seg = dec(t);
`ifdef SUM_DISPLAY_LZB_EN
        if (t == 0) begin
            tens_an  = 2'b11;
            tens_seg = 7'b1111111;
        end
`endif
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (bus.an == 2'b10) begin
                if (!seen_ones) check("seg_ones", int'(bus.seg), int'(dec(o)));
                seen_ones = 1;
            end else if (!seen_tens) begin
                check("an_tens", int'(bus.an), int'(tens_an));
                check("seg_tens", int'(bus.seg), int'(tens_seg));
                seen_tens = 1;
            end
        end
        check("display_phases_seen", int'(seen_ones & seen_tens), 1);
    endtask

    initial begin
        int vec_in [5] = '{62, 0, 9, 10, 63};
        int vec_t  [5] = '{6, 0, 0, 1, 6};
        int vec_o  [5] = '{2, 0, 9, 0, 3};
        int dc;
        int run;
        int changes;
        logic [1:0] prev_an;

        rst        = 1'b0;
        bus.load   = 1'b0;
        bus.sum_in = 6'd0;
        #1 rst = 1'b1;
        #2;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_tens", int'(bus.bcd_tens), 0);
        check("rst_ones", int'(bus.bcd_ones), 0);
        check("rst_an", int'(bus.an), 2);
        check("rst_seg", int'(bus.seg), 7'b1000000);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_an", int'(bus.an), 2);
        check("post_rst_seg", int'(bus.seg), 7'b1000000);
        check("post_rst_busy", int'(bus.busy), 0);

        for (int i = 0; i < 5; i++) begin
            run_conv(vec_in[i], vec_t[i], vec_o[i]);
            check_display(vec_t[i], vec_o[i]);
        end

        // Load while converting must not disturb the captured operand.
        dc = done_cnt;
        @(negedge clk);
        bus.sum_in = 6'd45;
        bus.load   = 1'b1;
        exp_q.push_back({3'd4, 4'd5});
        @(negedge clk);
        bus.load = 1'b0;
        @(negedge clk);
        bus.sum_in = 6'd7;
        bus.load   = 1'b1;
        @(negedge clk);
        bus.load   = 1'b0;
        bus.sum_in = 6'd0;
        repeat (10) @(negedge clk);
        check("ignored_load_single_done", done_cnt - dc, 1);
        check("ignored_load_tens", int'(bus.bcd_tens), 4);
        check("ignored_load_ones", int'(bus.bcd_ones), 5);

        // Back-to-back: second load presented during the done cycle.
        @(negedge clk);
        bus.sum_in = 6'd33;
        bus.load   = 1'b1;
        exp_q.push_back({3'd3, 4'd3});
        @(negedge clk);
        bus.load = 1'b0;
        repeat (6) @(negedge clk);
        check("b2b_first_done", int'(bus.done), 1);
        bus.sum_in = 6'd18;
        bus.load   = 1'b1;
        exp_q.push_back({3'd1, 4'd8});
        @(negedge clk);
        bus.load = 1'b0;
        repeat (6) @(negedge clk);
        check("b2b_second_done", int'(bus.done), 1);
        @(negedge clk);
        check("b2b_spacing", last_done_cyc - prev_done_cyc, 7);

        // Reset in the third conversion cycle aborts with no done.
        dc = done_cnt;
        bus.sum_in = 6'd50;
        bus.load   = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        bus.load = 1'b1;
        #1;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_tens", int'(bus.bcd_tens), 0);
        check("abort_ones", int'(bus.bcd_ones), 0);
        repeat (3) @(negedge clk);
        check("rst_load_ignored", int'(bus.busy), 0);
        bus.load = 1'b0;
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_no_done", done_cnt - dc, 0);
        check("abort_bcd_kept", int'({bus.bcd_tens, bus.bcd_ones}), 0);
        prev_t = 3'd0;
        prev_o = 4'd0;

        // Refresh: result 7, digit period 8 clocks.
        run_conv(7, 0, 7);
        prev_an = bus.an;
        run = 0;
        changes = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.an == prev_an) begin
                run++;
            end else begin
                if (changes > 0) check("an_period", run, 8);
                changes++;
                run = 1;
                prev_an = bus.an;
            end
`ifdef SUM_DISPLAY_LZB_EN
            check("lzb_an1_high", int'(bus.an[1]), 1);
            if (bus.an != 2'b10) check("lzb_seg_blank", int'(bus.seg), 7'b1111111);
`else
            check("an_legal", int'(bus.an == 2'b10 || bus.an == 2'b01), 1);
            if (bus.an == 2'b01) check("tens_zero_seg", int'(bus.seg), 7'b1000000);
`endif
            if (bus.an == 2'b10) check("ones_seven_seg", int'(bus.seg), 7'b1111000);
        end
        check("an_changes", int'(changes >= 3), 1);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sum_display.md
SUM_DISPLAY -- requirements
Module: sum_display

Interface
REQ-001 SHALL have parameter REFRESH_BITS, default 16, width of the free-running digit-refresh counter (digit period = 2^(REFRESH_BITS-1) clocks).
REQ-002 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port sum_in, input, 6, unsigned binary sum from the 5-bit adder stage (0..63 accepted).
REQ-005 SHALL have port load, input, 1, request to capture sum_in and start conversion.
REQ-006 SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-007 SHALL have port done, output, 1, single-cycle pulse when new BCD result is latched.
REQ-008 SHALL have port bcd_tens, output, 3, latched decimal tens digit (0..6).
REQ-009 SHALL have port bcd_ones, output, 4, latched decimal ones digit (0..9).
REQ-010 SHALL have port seg, output, 7, active-low segments, seg[0]=a .. seg[6]=g.
REQ-011 SHALL have port an, output, 2, active-low digit enables, an[0]=ones, an[1]=tens.

Function
REQ-012 SHALL implement FSM with states IDLE and CONV.
REQ-013 In IDLE, load=1 at edge k SHALL capture sum_in, clear the BCD shift register, and enter CONV.
REQ-014 load while in CONV SHALL be ignored; the captured operand SHALL not change.
REQ-015 CONV SHALL run shift-add-3 (double dabble): one iteration per clock at edges k+1..k+6; per iteration, add 3 to each BCD nibble >=5, then shift {tens,ones,bin} left by one.
REQ-016 busy SHALL be 1 in the cycles after edges k..k+5 and 0 otherwise.
REQ-017 At edge k+6 the FSM SHALL return to IDLE, update bcd_tens/bcd_ones, and assert done for exactly one cycle.
REQ-018 load during the done cycle SHALL be accepted (back-to-back throughput: one result per 7 clocks).
REQ-019 bcd_tens/bcd_ones SHALL hold the previous result throughout a conversion; the display never shows partial values.
REQ-020 Refresh counter SHALL free-run and wrap from all-ones to zero; MSB=0 selects ones (an=2'b10), MSB=1 selects tens (an=2'b01).
REQ-021 seg SHALL decode the selected digit: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000 (shown g..a); any other code SHALL give 1111111.
REQ-022 seg/an SHALL be registered (one clock after counter/digit change).

Reset
REQ-023 rst=1 SHALL immediately force: FSM IDLE, busy=0, done=0, bcd_tens=0, bcd_ones=0, refresh counter=0, an=2'b10, seg=1000000.
REQ-024 Reset during CONV SHALL abort the conversion with no done pulse; load while rst=1 SHALL be ignored.

Configuration
REQ-025 Macro SUM_DISPLAY_LZB_EN defined: when bcd_tens=0 the tens slot SHALL drive an=2'b11 and seg=1111111 (leading-zero blanking).
REQ-026 Macro SUM_DISPLAY_LZB_EN undefined: the tens slot SHALL always display its digit, including 0.

Verification
REQ-027 Reset release -> bcd=0/0, busy=0, done=0, an=2'b10, seg=1000000.
REQ-028 sum_in=62, load pulse at edge k -> busy for 6 cycles, done at k+6, bcd_tens=6, bcd_ones=2; also 0->0/0, 9->0/9, 10->1/0, 63->6/3.
REQ-029 load 45, then load with sum_in=7 two cycles later -> result 4/5, single done pulse.
REQ-030 load 33 then load 18 in done cycle -> done pulses at k+6 and k+13, results 3/3 then 1/8.
REQ-031 rst asserted at third CONV cycle after load 50 -> no done, bcd=0/0, busy=0 immediately.
REQ-032 REFRESH_BITS=4, result 7 -> an alternates every 8 clocks; with SUM_DISPLAY_LZB_EN an[1] never low, without it the tens slot shows seg=1000000.
